gpnae_job_scheduler: RTL and testbench
======================================

Name: gpnae_job_scheduler

Overview:
Shares one gpnae engine between NUM_REQ requesters, one job at a time. Each job is a sample stream closed by a last beat, plus a control word (activation select) and a terms count. The block arbitrates round-robin and streams the winner's samples into the engine FIFO. It then waits for engine done and returns the result tagged with the requester id; a timeout guards a hung engine.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_WIDTH, 32, sample/result width (IEEE-754 single)
ADDR_LINES, 5, engine FIFO address bits; max job length 2**ADDR_LINES beats
CONTROL_WIDTH, 2, engine control word width
TIMEOUT_CYCLES, 1024, max cycles in WAIT_DONE before abort
ID_W, $clog2(NUM_REQ), requester id width (localparam)

Ports:
clk_i  in  1  single clock
rst_i  in  1  synchronous, active-high reset
req_valid_i  in  NUM_REQ  per-requester beat valid
req_ready_o  out  NUM_REQ  per-requester beat accept
req_data_i  in  NUM_REQ*DATA_WIDTH  packed samples, requester k at [k*DATA_WIDTH +: DATA_WIDTH]
req_last_i  in  NUM_REQ  final beat of job
req_ctrl_i  in  NUM_REQ*CONTROL_WIDTH  job control word (01 SeLU, 10 sigmoid, 11 tanh, 00 invalid)
req_terms_i  in  NUM_REQ*ADDR_LINES  job MAC term count
eng_signal_o  out  DATA_WIDTH  engine sample
eng_wr_en_o  out  1  engine FIFO write
eng_last_o  out  1  engine last
eng_terms_o  out  ADDR_LINES  engine terms
eng_control_word_o  out  CONTROL_WIDTH  engine control word
eng_full_i  in  1  engine FIFO full
eng_result_i  in  DATA_WIDTH  engine final result
eng_done_i  in  1  engine done pulse
eng_flush_o  out  1  one-cycle engine reset request on timeout
rsp_valid_o  out  1  response valid
rsp_ready_i  in  1  response accept
rsp_id_o  out  ID_W  requester that owns the response
rsp_result_o  out  DATA_WIDTH  result
rsp_err_o  out  1  1 means invalid control word or timeout
busy_o  out  1  state != IDLE

Behaviour:
- Reset (rst_i high at a clk_i edge, any state): state IDLE, rr pointer 0, beat/timeout counters 0. All outputs 0, including every req_ready_o bit, all eng_* outputs and all rsp_* outputs. Reset mid-job abandons the job without a response.
- FSM states: IDLE, STREAM, DRAIN, WAIT_DONE, RESPOND.
- IDLE, when any req_valid_i bit is set:
  - Grant g = first set bit at or after pointer, scanning upward with wrap.
  - Latch g, req_ctrl_i[g] and req_terms_i[g].
  - Go to STREAM if ctrl != 0, else to DRAIN.
  - Arbitration costs 1 cycle; no beat is accepted in IDLE.
- eng_control_word_o and eng_terms_o are driven from the latched values from the cycle after grant until the return to IDLE; 0 in IDLE.
- STREAM:
  - req_ready_o[g] = ~eng_full_i (combinational). All other ready bits are 0.
  - Transfer = req_valid_i[g] & req_ready_o[g].
  - eng_wr_en_o = transfer; eng_signal_o = req_data_i[g]; eng_last_o = transfer & (req_last_i[g] | beat count == 2**ADDR_LINES-1). Zero latency.
  - Beat counter increments per transfer. On the last transfer go to WAIT_DONE.
  - A deasserted req_valid_i holds the grant (no timeout in STREAM).
  - Reaching 2**ADDR_LINES beats forces last and truncates the job; any later beats from g wait for a future grant.
- DRAIN (invalid ctrl 00): req_ready_o[g] = 1; the engine is not written. On the last beat, load rsp_result = 0, rsp_err = 1 and go to RESPOND.
- WAIT_DONE:
  - Timeout counter increments each cycle.
  - On eng_done_i, capture eng_result_i and set rsp_err = 0, then go to RESPOND.
  - Else, when the counter reaches TIMEOUT_CYCLES-1, set rsp_result = 0, rsp_err = 1, pulse eng_flush_o for 1 cycle, and go to RESPOND.
  - If done and timeout land in the same cycle, done wins.
  - eng_done_i outside WAIT_DONE is ignored.
- RESPOND:
  - rsp_valid_o = 1 with rsp_id_o = g; rsp_result_o and rsp_err_o are held stable.
  - On rsp_valid_o & rsp_ready_i: pointer = (g+1) mod NUM_REQ, clear counters, go to IDLE.
  - No new grant is issued until the response is accepted.
- Response registers are updated only on the transitions into RESPOND.

Test Plan:
- Single job: req0 sends 4 beats (1.0, 2.0, 3.0, 4.0 = 0x3F800000...), last on beat 4, ctrl 10, terms 4; model done 6 cycles after last with result 0x3F7FFFFF -> exactly 4 eng_wr_en_o pulses, eng_last_o on the 4th; rsp_valid_o with id 0, result 0x3F7FFFFF, err 0.
- Round-robin: req0..req3 all valid with 1-beat jobs -> grants in order 0, 1, 2, 3, then 0 again if req0 is re-asserted; each rsp_id_o matches.
- Backpressure: eng_full_i high for 3 cycles mid-stream -> req_ready_o[g] = 0 for those cycles, no eng_wr_en_o, no beat lost or duplicated.
- Invalid ctrl 00 with a 2-beat job -> no eng_wr_en_o, both beats accepted, rsp_err_o = 1, result 0.
- Timeout: TIMEOUT_CYCLES = 16, done never asserted -> eng_flush_o pulse 16 cycles after entering WAIT_DONE, then rsp_err_o = 1; done and timeout in the same cycle -> err 0 with the engine result.
- Reset in WAIT_DONE and in RESPOND -> next cycle all outputs 0, busy_o 0, next grant goes to req0; rsp_ready_i held low 5 cycles -> rsp_valid_o and rsp_result_o remain stable.

Source files
------------

// File: rtl/gpnae_job_scheduler.sv
// Round-robin job scheduler sharing one gpnae engine between NUM_REQ requesters:
// streams the granted job into the engine FIFO, waits for done (with timeout) and returns a tagged result.
module gpnae_job_scheduler #(
    parameter int NUM_REQ        = 4,
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_LINES     = 5,
    parameter int CONTROL_WIDTH  = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic [NUM_REQ-1:0]                 req_valid_i,
    output logic [NUM_REQ-1:0]                 req_ready_o,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]      req_data_i,
    input  logic [NUM_REQ-1:0]                 req_last_i,
    input  logic [NUM_REQ*CONTROL_WIDTH-1:0]   req_ctrl_i,
    input  logic [NUM_REQ*ADDR_LINES-1:0]      req_terms_i,
    output logic [DATA_WIDTH-1:0]              eng_signal_o,
    output logic                               eng_wr_en_o,
    output logic                               eng_last_o,
    output logic [ADDR_LINES-1:0]              eng_terms_o,
    output logic [CONTROL_WIDTH-1:0]           eng_control_word_o,
    input  logic                               eng_full_i,
    input  logic [DATA_WIDTH-1:0]              eng_result_i,
    input  logic                               eng_done_i,
    output logic                               eng_flush_o,
    output logic                               rsp_valid_o,
    input  logic                               rsp_ready_i,
    output logic [$clog2(NUM_REQ)-1:0]         rsp_id_o,
    output logic [DATA_WIDTH-1:0]              rsp_result_o,
    output logic                               rsp_err_o,
    output logic                               busy_o
);
    localparam int ID_W = $clog2(NUM_REQ);
    localparam int TW   = $clog2(TIMEOUT_CYCLES) + 1;

    typedef enum logic [2:0] {S_IDLE, S_STREAM, S_DRAIN, S_WAIT_DONE, S_RESPOND} state_e;

    state_e                   state_q;
    logic [ID_W-1:0]          ptr_q, gnt_q, gnt_d;
    logic [CONTROL_WIDTH-1:0] ctrl_q, gnt_ctrl;
    logic [ADDR_LINES-1:0]    terms_q, gnt_terms, beat_q;
    logic [TW-1:0]            tmo_q;
    logic [DATA_WIDTH-1:0]    rsp_result_q, sel_data;
    logic                     rsp_err_q, flush_q, found, sel_valid, sel_last, xfer, last_beat;
    int unsigned              scan;

    assign sel_valid = req_valid_i[gnt_q];
    assign sel_last  = req_last_i[gnt_q];
    assign sel_data  = req_data_i[gnt_q*DATA_WIDTH +: DATA_WIDTH];
    assign gnt_ctrl  = req_ctrl_i[gnt_d*CONTROL_WIDTH +: CONTROL_WIDTH];
    assign gnt_terms = req_terms_i[gnt_d*ADDR_LINES +: ADDR_LINES];
    // A full FIFO address range forces the last beat and truncates the job.
    assign last_beat = sel_last | (&beat_q);

    // First valid requester at or after the pointer, scanning upward with wrap.
    always_comb begin
        gnt_d = ptr_q;
        found = 1'b0;
        scan  = 0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            scan = (32'(ptr_q) + i) % 32'(NUM_REQ);
            if (!found && req_valid_i[scan[ID_W-1:0]]) begin
                found = 1'b1;
                gnt_d = scan[ID_W-1:0];
            end
        end
    end

    always_comb begin
        req_ready_o = '0;
        xfer        = 1'b0;
        if (state_q == S_STREAM) begin
            req_ready_o[gnt_q] = ~eng_full_i;
            xfer               = sel_valid & ~eng_full_i;
        end else if (state_q == S_DRAIN) begin
            req_ready_o[gnt_q] = 1'b1;
            xfer               = sel_valid;
        end
    end

    assign eng_wr_en_o        = (state_q == S_STREAM) & xfer;
    assign eng_last_o         = eng_wr_en_o & last_beat;
    assign eng_signal_o       = (state_q == S_STREAM) ? sel_data : '0;
    assign eng_terms_o        = (state_q != S_IDLE) ? terms_q : '0;
    assign eng_control_word_o = (state_q != S_IDLE) ? ctrl_q : '0;
    assign eng_flush_o        = flush_q;
    assign rsp_valid_o        = (state_q == S_RESPOND);
    assign rsp_id_o           = rsp_valid_o ? gnt_q : '0;
    assign rsp_result_o       = rsp_valid_o ? rsp_result_q : '0;
    assign rsp_err_o          = rsp_valid_o & rsp_err_q;
    assign busy_o             = (state_q != S_IDLE);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            ptr_q        <= '0;
            gnt_q        <= '0;
            ctrl_q       <= '0;
            terms_q      <= '0;
            beat_q       <= '0;
            tmo_q        <= '0;
            rsp_result_q <= '0;
            rsp_err_q    <= 1'b0;
            flush_q      <= 1'b0;
        end else begin
            flush_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (found) begin
                        gnt_q   <= gnt_d;
                        ctrl_q  <= gnt_ctrl;
                        terms_q <= gnt_terms;
                        state_q <= (gnt_ctrl != '0) ? S_STREAM : S_DRAIN;
                    end
                end
                S_STREAM: begin
                    if (xfer) begin
                        beat_q <= beat_q + 1'b1;
                        if (last_beat) state_q <= S_WAIT_DONE;
                    end
                end
                S_DRAIN: begin
                    if (xfer) begin
                        beat_q <= beat_q + 1'b1;
                        if (last_beat) begin
                            rsp_result_q <= '0;
                            rsp_err_q    <= 1'b1;
                            state_q      <= S_RESPOND;
                        end
                    end
                end
                S_WAIT_DONE: begin
                    tmo_q <= tmo_q + 1'b1;
                    if (eng_done_i) begin
                        rsp_result_q <= eng_result_i;
                        rsp_err_q    <= 1'b0;
                        state_q      <= S_RESPOND;
                    end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                        rsp_result_q <= '0;
                        rsp_err_q    <= 1'b1;
                        flush_q      <= 1'b1;
                        state_q      <= S_RESPOND;
                    end
                end
                S_RESPOND: begin
                    if (rsp_ready_i) begin
                        ptr_q   <= (gnt_q == ID_W'(NUM_REQ - 1)) ? '0 : gnt_q + 1'b1;
                        beat_q  <= '0;
                        tmo_q   <= '0;
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_gpnae_job_scheduler.sv
// Directed bench for gpnae_job_scheduler: table of jobs with hand-computed responses,
// plus sequences for round-robin order, backpressure and reset in mid-job states.
module tb_gpnae_job_scheduler;
    localparam int NR = 4;
    localparam int DW = 32;
    localparam int AL = 5;
    localparam int CW = 2;
    localparam int TO = 16;

    logic              clk = 1'b0;
    logic              rst_i;
    logic [NR-1:0]     req_valid_i, req_ready_o, req_last_i;
    logic [NR*DW-1:0]  req_data_i;
    logic [NR*CW-1:0]  req_ctrl_i;
    logic [NR*AL-1:0]  req_terms_i;
    logic [DW-1:0]     eng_signal_o, eng_result_i, rsp_result_o;
    logic              eng_wr_en_o, eng_last_o, eng_full_i, eng_done_i, eng_flush_o;
    logic [AL-1:0]     eng_terms_o;
    logic [CW-1:0]     eng_control_word_o;
    logic              rsp_valid_o, rsp_ready_i, rsp_err_o, busy_o;
    logic [1:0]        rsp_id_o;

    gpnae_job_scheduler #(
        .NUM_REQ(NR), .DATA_WIDTH(DW), .ADDR_LINES(AL), .CONTROL_WIDTH(CW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_i(clk), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_data_i(req_data_i),
        .req_last_i(req_last_i), .req_ctrl_i(req_ctrl_i), .req_terms_i(req_terms_i),
        .eng_signal_o(eng_signal_o), .eng_wr_en_o(eng_wr_en_o), .eng_last_o(eng_last_o),
        .eng_terms_o(eng_terms_o), .eng_control_word_o(eng_control_word_o),
        .eng_full_i(eng_full_i), .eng_result_i(eng_result_i), .eng_done_i(eng_done_i),
        .eng_flush_o(eng_flush_o), .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_id_o(rsp_id_o), .rsp_result_o(rsp_result_o), .rsp_err_o(rsp_err_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         req;
        logic [1:0] ctrl;
        int         nb;       // beats to load (0 = continue what is pending)
        int         dly;      // engine done delay after last beat (0 = never)
        logic [31:0] eres;
        int         hold;     // cycles to hold rsp_ready_i low
        int         exp_wr;
        int         exp_acc;
        logic       exp_err;
        logic [31:0] exp_res;
        int         exp_flush;
    } job_t;

    int total = 0, bad = 0;
    int rem[NR], beat[NR];
    logic [1:0]  rctl[NR];
    logic [4:0]  rterm[NR];
    logic [31:0] samp[4];
    int cyc = 0, wr_cnt, last_cnt, last_at, flush_cnt, flush_cyc, acc_cnt, last_xfer_cyc;
    logic rsp_seen;
    int eng_dly = 0;
    job_t jobs[7];
    job_t j;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] sample_of(input int k, input int i);
        return samp[i % 4] + 32'(k * 256 + i / 4);
    endfunction

    task automatic drive_req();
        for (int k = 0; k < NR; k++) begin
            req_valid_i[k]             = (rem[k] > 0);
            req_last_i[k]              = (rem[k] == 1);
            req_data_i[k*DW +: DW]     = sample_of(k, beat[k]);
            req_ctrl_i[k*CW +: CW]     = rctl[k];
            req_terms_i[k*AL +: AL]    = rterm[k];
        end
    endtask

    task automatic step();
        int xk;
        drive_req();
        #1;
        xk = -1;
        for (int k = 0; k < NR; k++)
            if (req_valid_i[k] && req_ready_o[k]) xk = k;
        if (eng_wr_en_o) begin
            wr_cnt++;
            chk("wr_owner", 64'(xk >= 0), 64'd1);
            if (xk >= 0) begin
                chk("eng_signal", 64'(eng_signal_o), 64'(sample_of(xk, beat[xk])));
                chk("eng_ctrl", 64'(eng_control_word_o), 64'(rctl[xk]));
                chk("eng_terms", 64'(eng_terms_o), 64'(rterm[xk]));
            end
        end
        if (eng_last_o) begin
            last_cnt++;
            last_at = wr_cnt;
        end
        if (eng_flush_o) begin
            flush_cnt++;
            flush_cyc = cyc;
        end
        if (eng_full_i) begin
            chk("full_ready", 64'(req_ready_o), 64'd0);
            chk("full_wr", 64'(eng_wr_en_o), 64'd0);
        end
        if (xk >= 0) begin
            beat[xk]++;
            rem[xk]--;
            acc_cnt++;
            last_xfer_cyc = cyc;
        end
        rsp_seen = rsp_valid_o;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic load_req(input int k, input int nb, input logic [1:0] c);
        rem[k]   = nb;
        beat[k]  = 0;
        rctl[k]  = c;
        rterm[k] = 5'(nb);
    endtask

    task automatic start_job(input job_t jb);
        if (jb.nb > 0) load_req(jb.req, jb.nb, jb.ctrl);
        eng_dly      = jb.dly;
        eng_result_i = jb.eres;
        wr_cnt = 0; last_cnt = 0; last_at = 0; flush_cnt = 0; acc_cnt = 0;
        rsp_seen = 1'b0;
    endtask

    task automatic finish_job(input string nm, input job_t jb);
        int n = 0;
        while (!rsp_seen && n < 400) begin
            step();
            n++;
        end
        chk({nm, "_rsp_seen"}, 64'(rsp_seen), 64'd1);
        chk({nm, "_rsp_id"}, 64'(rsp_id_o), 64'(jb.req));
        chk({nm, "_rsp_result"}, 64'(rsp_result_o), 64'(jb.exp_res));
        chk({nm, "_rsp_err"}, 64'(rsp_err_o), 64'(jb.exp_err));
        for (int h = 0; h < jb.hold; h++) begin
            step();
            chk({nm, "_hold_valid"}, 64'(rsp_valid_o), 64'd1);
            chk({nm, "_hold_result"}, 64'(rsp_result_o), 64'(jb.exp_res));
        end
        rsp_ready_i = 1'b1;
        step();
        rsp_ready_i = 1'b0;
        chk({nm, "_idle_after"}, 64'(busy_o), 64'd0);
        chk({nm, "_rsp_dropped"}, 64'(rsp_valid_o), 64'd0);
        chk({nm, "_wr_cnt"}, 64'(wr_cnt), 64'(jb.exp_wr));
        chk({nm, "_acc_cnt"}, 64'(acc_cnt), 64'(jb.exp_acc));
        chk({nm, "_last_cnt"}, 64'(last_cnt), 64'(jb.exp_wr > 0));
        if (jb.exp_wr > 0) chk({nm, "_last_pos"}, 64'(last_at), 64'(jb.exp_wr));
        chk({nm, "_flush_cnt"}, 64'(flush_cnt), 64'(jb.exp_flush));
        if (jb.exp_flush > 0)
            chk({nm, "_flush_delay"}, 64'(flush_cyc - last_xfer_cyc - 1), 64'(TO));
    endtask

    task automatic check_all_zero(input string nm);
        chk({nm, "_ready"}, 64'(req_ready_o), 64'd0);
        chk({nm, "_wr"}, 64'(eng_wr_en_o), 64'd0);
        chk({nm, "_signal"}, 64'(eng_signal_o), 64'd0);
        chk({nm, "_last"}, 64'(eng_last_o), 64'd0);
        chk({nm, "_terms"}, 64'(eng_terms_o), 64'd0);
        chk({nm, "_ctrl"}, 64'(eng_control_word_o), 64'd0);
        chk({nm, "_flush"}, 64'(eng_flush_o), 64'd0);
        chk({nm, "_rvalid"}, 64'(rsp_valid_o), 64'd0);
        chk({nm, "_rid"}, 64'(rsp_id_o), 64'd0);
        chk({nm, "_rresult"}, 64'(rsp_result_o), 64'd0);
        chk({nm, "_rerr"}, 64'(rsp_err_o), 64'd0);
        chk({nm, "_busy"}, 64'(busy_o), 64'd0);
    endtask

    task automatic do_reset(input string nm);
        for (int k = 0; k < NR; k++) rem[k] = 0;
        rst_i = 1'b1;
        step();
        check_all_zero(nm);
        rst_i = 1'b0;
    endtask

    // Engine model: raises done for one cycle eng_dly cycles after a last write.
    initial begin
        int cnt = 0;
        eng_done_i = 1'b0;
        forever begin
            @(negedge clk);
            eng_done_i = 1'b0;
            if (eng_wr_en_o && eng_last_o) begin
                cnt = eng_dly;
            end else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) eng_done_i = 1'b1;
            end
        end
    end

    initial begin
        samp[0] = 32'h3F800000; samp[1] = 32'h40000000;
        samp[2] = 32'h40400000; samp[3] = 32'h40800000;
        for (int k = 0; k < NR; k++) begin
            rem[k] = 0; beat[k] = 0; rctl[k] = 2'b00; rterm[k] = '0;
        end
        //          req ctrl   nb  dly eres          hold wr acc err  exp_res       flush
        jobs[0] = '{0, 2'b10, 4,  6,  32'h3F7FFFFF, 5,   4,  4, 1'b0, 32'h3F7FFFFF, 0};
        jobs[1] = '{2, 2'b00, 2,  0,  32'h0,        0,   0,  2, 1'b1, 32'h0,        0};
        jobs[2] = '{1, 2'b11, 1,  16, 32'h40490FDB, 0,   1,  1, 1'b0, 32'h40490FDB, 0};
        jobs[3] = '{3, 2'b01, 3,  0,  32'hDEADBEEF, 0,   3,  3, 1'b1, 32'h0,        1};
        jobs[4] = '{1, 2'b01, 2,  17, 32'h12345678, 0,   2,  2, 1'b1, 32'h0,        1};
        jobs[5] = '{3, 2'b10, 34, 2,  32'hAAAA5555, 0,   32, 32, 1'b0, 32'hAAAA5555, 0};
        jobs[6] = '{3, 2'b10, 0,  2,  32'h5555AAAA, 0,   2,  2, 1'b0, 32'h5555AAAA, 0};

        rst_i = 1'b1; rsp_ready_i = 1'b0; eng_full_i = 1'b0; eng_result_i = '0;
        req_valid_i = '1; req_last_i = '1; req_data_i = '1; req_ctrl_i = '1; req_terms_i = '1;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        do_reset("reset2");

        for (int t = 0; t < 7; t++) begin
            start_job(jobs[t]);
            finish_job($sformatf("job%0d", t), jobs[t]);
        end

        // Round-robin: all four requesters pending at once, then req0 again.
        do_reset("rr_reset");
        for (int k = 0; k < NR; k++) load_req(k, 1, 2'b10);
        for (int k = 0; k < NR; k++) begin
            j = '{k, 2'b10, 0, 3, 32'h100 + 32'(k), 0, 1, 1, 1'b0, 32'h100 + 32'(k), 0};
            start_job(j);
            finish_job($sformatf("rr%0d", k), j);
        end
        j = '{0, 2'b10, 1, 3, 32'h200, 0, 1, 1, 1'b0, 32'h200, 0};
        start_job(j);
        finish_job("rr_again", j);

        // Backpressure: engine full for 3 cycles after the second beat.
        j = '{0, 2'b10, 4, 4, 32'h3E000000, 0, 4, 4, 1'b0, 32'h3E000000, 0};
        start_job(j);
        for (int n = 0; n < 50 && acc_cnt < 2; n++) step();
        chk("bp_two_beats", 64'(acc_cnt), 64'd2);
        eng_full_i = 1'b1;
        repeat (3) step();
        eng_full_i = 1'b0;
        finish_job("bp", j);

        // Reset in WAIT_DONE: pointer returns to 0, so req0 beats pending req1.
        j = '{2, 2'b10, 2, 0, 32'h0, 0, 2, 2, 1'b0, 32'h0, 0};
        start_job(j);
        for (int n = 0; n < 50 && acc_cnt < 2; n++) step();
        repeat (3) step();
        chk("rw_busy_before", 64'(busy_o), 64'd1);
        do_reset("rst_wait");
        load_req(1, 1, 2'b01);
        j = '{0, 2'b10, 1, 2, 32'h11, 0, 1, 1, 1'b0, 32'h11, 0};
        start_job(j);
        finish_job("rw_req0", j);
        j = '{1, 2'b01, 0, 2, 32'h22, 0, 1, 1, 1'b0, 32'h22, 0};
        start_job(j);
        finish_job("rw_req1", j);

        // Reset in RESPOND: response is abandoned and req0 wins over req3.
        j = '{3, 2'b10, 1, 2, 32'h33, 0, 1, 1, 1'b0, 32'h33, 0};
        start_job(j);
        for (int n = 0; n < 50 && !rsp_seen; n++) step();
        chk("rr_resp_reached", 64'(rsp_valid_o), 64'd1);
        do_reset("rst_resp");
        load_req(3, 1, 2'b10);
        j = '{0, 2'b11, 1, 2, 32'h44, 0, 1, 1, 1'b0, 32'h44, 0};
        start_job(j);
        finish_job("rp_req0", j);
        j = '{3, 2'b10, 0, 2, 32'h55, 0, 1, 1, 1'b0, 32'h55, 0};
        start_job(j);
        finish_job("rp_req3", j);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
